// File: rtl/hex_display_pkg.sv
// Shared display package: seven-segment glyph table (active-low, bit 0 = segment a)
// and the all-off pattern used by the display blocks.
package hex_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_DARK_AL = 7'h7F;

  localparam seg7_t HEX_GLYPH_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg7_t hex_glyph_al(input logic [3:0] nib);
    return HEX_GLYPH_AL[nib];
  endfunction

endpackage

// File: rtl/hexdigit.sv
// Single hex digit decoder: 4-bit value to active-low seven-segment glyph.
module hexdigit
  import hex_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = hex_glyph_al(digit);

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display controller: shadow capture on load, leading-zero
// suppression, per-digit blank/blink and registered segment outputs.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [N_DIGITS-1:0]   blink_in,
  input  logic                  lz_suppress,
  output logic [7*N_DIGITS-1:0] seg_out,
  output logic                  blink_phase
);

  localparam int    CNT_W = $clog2(BLINK_DIV);
  localparam seg7_t DARK  = (ACTIVE_LOW != 0) ? SEG_DARK_AL : ~SEG_DARK_AL;

  logic [4*N_DIGITS-1:0] data_q;
  logic [N_DIGITS-1:0]   blank_q;
  logic [N_DIGITS-1:0]   blink_q;
  logic                  shown_q;
  logic [CNT_W-1:0]      presc_q;
  logic [7*N_DIGITS-1:0] seg_nxt;
  seg7_t                 glyph_al [N_DIGITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      blank_q <= '0;
      blink_q <= '0;
      shown_q <= 1'b0;
    end else if (load) begin
      data_q  <= data_in;
      blank_q <= blank_in;
      blink_q <= blink_in;
      shown_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      blink_phase <= 1'b0;
    end else if (presc_q == CNT_W'(BLINK_DIV - 1)) begin
      presc_q     <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_DIGITS; g++) begin : g_digit
      hexdigit u_hexdigit (
        .digit (data_q[4*g +: 4]),
        .seg   (glyph_al[g])
      );
    end
  endgenerate

  // Walk from the top digit down: 'above' stays 1 while every digit so far is zero or blanked.
  always_comb begin
    logic above;
    logic dark;
    seg_nxt = '0;
    above   = 1'b1;
    dark    = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      above = above & ((data_q[4*i +: 4] == 4'h0) | blank_q[i]);
      dark  = ~shown_q | blank_q[i] | (blink_q[i] & blink_phase)
            | (lz_suppress & above & (i != 0));
      if (dark)
        seg_nxt[7*i +: 7] = DARK;
      else if (ACTIVE_LOW != 0)
        seg_nxt[7*i +: 7] = glyph_al[i];
      else
        seg_nxt[7*i +: 7] = ~glyph_al[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seg_out <= {N_DIGITS{DARK}};
    else          seg_out <= seg_nxt;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl (4 digits, blink divider 4, active-low segments).
module tb_hex_display_ctrl;

  localparam int ND = 4;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   data_in = '0;
  logic [3:0]    blank_in = '0;
  logic [3:0]    blink_in = '0;
  logic          lz_suppress = 1'b0;
  logic [27:0]   seg_out;
  logic          blink_phase;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  hex_display_ctrl #(.N_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(1)) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .load        (load),
    .data_in     (data_in),
    .blank_in    (blank_in),
    .blink_in    (blink_in),
    .lz_suppress (lz_suppress),
    .seg_out     (seg_out),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [27:0] render(input logic [15:0] d, input logic [3:0] bl,
                                         input logic [3:0] bk, input logic sh,
                                         input logic ph, input logic lz);
    logic [27:0] r;
    logic sup, dark;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      sup = 1'b0;
      if (lz && i > 0) begin
        sup = 1'b1;
        for (int j = i; j < ND; j++)
          if (d[4*j +: 4] != 4'h0 && !bl[j]) sup = 1'b0;
      end
      dark = !sh || bl[i] || (bk[i] && ph) || sup;
      r[7*i +: 7] = dark ? 7'h7F : glyph_tab[d[4*i +: 4]];
    end
    return r;
  endfunction

  // Model: what the display must show after each edge, from the values visible before it.
  logic [15:0] m_data = '0;
  logic [3:0]  m_blank = '0, m_blink = '0;
  logic        m_shown = 1'b0;
  int          m_edges = 0;
  logic        exp_phase = 1'b0;
  logic [27:0] exp_seg = 28'hFFFFFFF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data = '0; m_blank = '0; m_blink = '0; m_shown = 1'b0;
      m_edges = 0; exp_phase = 1'b0; exp_seg = 28'hFFFFFFF;
    end else begin
      exp_seg = render(m_data, m_blank, m_blink, m_shown, exp_phase, lz_suppress);
      if (load) begin
        m_data = data_in; m_blank = blank_in; m_blink = blink_in; m_shown = 1'b1;
      end
      m_edges++;
      exp_phase = ((m_edges / BD) % 2) == 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (seg_out !== exp_seg) begin
        failures++;
        $display("FAIL seg_cycle t=%0t actual=%h expected=%h", $time, seg_out, exp_seg);
      end
      checks++;
      if (blink_phase !== exp_phase) begin
        failures++;
        $display("FAIL phase_cycle t=%0t actual=%0b expected=%0b", $time, blink_phase, exp_phase);
      end
    end
  end

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk);
    data_in = d; blank_in = bl; blink_in = bk; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_phase(input logic v, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge clk);
      if (blink_phase === v) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_phase_%0b actual=timeout expected=%0b", v, v);
    end
  endtask

  initial begin
    bit ok;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_seg", seg_out, 28'hFFFFFFF);
    chk("reset_phase", {27'd0, blink_phase}, 28'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_wrap_phase", {27'd0, blink_phase}, 28'd0);
    @(negedge clk);
    chk("wrap_phase", {27'd0, blink_phase}, 28'd1);
    chk("no_load_dark", seg_out, 28'hFFFFFFF);
    repeat (4) @(negedge clk);
    chk("phase_back", {27'd0, blink_phase}, 28'd0);

    do_load(16'h12AF, 4'b0, 4'b0);
    chk("latency_one_edge_dark", seg_out, 28'hFFFFFFF);
    @(negedge clk);
    chk("load_12AF", seg_out, {7'h79, 7'h24, 7'h08, 7'h0E});
    repeat (5) @(negedge clk);
    chk("hold_12AF", seg_out, {7'h79, 7'h24, 7'h08, 7'h0E});

    lz_suppress = 1'b1;
    do_load(16'h0050, 4'b0, 4'b0);
    @(negedge clk);
    chk("lz_0050", seg_out, {7'h7F, 7'h7F, 7'h12, 7'h40});
    do_load(16'h0000, 4'b0, 4'b0);
    @(negedge clk);
    chk("lz_0000", seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    lz_suppress = 1'b0;
    @(negedge clk);
    chk("nolz_0000", seg_out, {7'h40, 7'h40, 7'h40, 7'h40});

    lz_suppress = 1'b1;
    do_load(16'h2034, 4'b1000, 4'b0);
    @(negedge clk);
    chk("lz_over_blank", seg_out, {7'h7F, 7'h7F, 7'h30, 7'h19});
    lz_suppress = 1'b0;

    do_load(16'h1234, 4'b0, 4'b0001);
    @(negedge clk);
    wait_phase(1'b1, ok);
    @(negedge clk);
    chk("blink_dark", seg_out, {7'h79, 7'h24, 7'h30, 7'h7F});
    wait_phase(1'b0, ok);
    @(negedge clk);
    chk("blink_lit", seg_out, {7'h79, 7'h24, 7'h30, 7'h19});

    do_load(16'h1234, 4'b0100, 4'b0);
    @(negedge clk);
    chk("blank_d2", seg_out, {7'h79, 7'h7F, 7'h30, 7'h19});
    repeat (6) @(negedge clk);
    chk("blank_d2_hold", seg_out, {7'h79, 7'h7F, 7'h30, 7'h19});

    blank_in = 4'b0; blink_in = 4'b0;
    data_in = 16'h1111; load = 1'b1;
    @(negedge clk);
    data_in = 16'h2222;
    @(negedge clk);
    chk("burst_1111", seg_out, {4{7'h79}});
    data_in = 16'h3333;
    @(negedge clk);
    chk("burst_2222", seg_out, {4{7'h24}});
    load = 1'b0;
    @(negedge clk);
    chk("burst_3333", seg_out, {4{7'h30}});

    do_load(16'h5555, 4'b0, 4'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_seg", seg_out, 28'hFFFFFFF);
    chk("async_reset_phase", {27'd0, blink_phase}, 28'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_dark", seg_out, 28'hFFFFFFF);
    chk("post_reset_phase0", {27'd0, blink_phase}, 28'd0);
    @(negedge clk);
    chk("post_reset_phase1", {27'd0, blink_phase}, 28'd1);
    do_load(16'h0007, 4'b0, 4'b0);
    @(negedge clk);
    chk("first_load_after_reset", seg_out, {7'h40, 7'h40, 7'h40, 7'h78});
    repeat (2) @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of seven-segment digits driven (1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clock cycles per blink half-period (>=2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 = segment on when bit is 0 (board convention); 0 = inverted.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load  input  1  capture strobe for data_in/blank_in/blink_in.
REQ-007 SHALL have port data_in  input  4*N_DIGITS  nibble per digit, digit 0 in bits [3:0].
REQ-008 SHALL have port blank_in  input  N_DIGITS  per-digit force-off mask.
REQ-009 SHALL have port blink_in  input  N_DIGITS  per-digit blink enable.
REQ-010 SHALL have port lz_suppress  input  1  leading-zero suppression enable (live, not captured).
REQ-011 SHALL have port seg_out  output  7*N_DIGITS  registered segments, digit 0 in bits [6:0].
REQ-012 SHALL have port blink_phase  output  1  current blink phase (1 = blinking digits dark).

Function
REQ-013 SHALL capture data_in, blank_in, blink_in into shadow registers on every rising edge with load=1; no ready signal, every load accepted.
REQ-014 SHALL set an internal shown flag on the first accepted load; while shown=0 all digits SHALL be dark.
REQ-015 SHALL update seg_out two rising edges after the edge sampling load=1 (shadow, then output register); load asserted on consecutive cycles SHALL give seg_out tracking each value with the same latency.
REQ-016 SHALL decode each shadow nibble 0..F to the standard hex glyph (0-9, A, b, C, d, E, F).
REQ-017 SHALL render a digit dark when any holds: shown=0; its blank bit=1; blink bit=1 and blink_phase=1; it is leading-zero-suppressed.
REQ-018 Leading-zero suppression, with lz_suppress=1: digit i (i>0) SHALL be suppressed when its nibble and all nibbles above it are 0 or themselves blanked by blank_in; digit 0 SHALL never be suppressed.
REQ-019 Dark SHALL mean all seven segments off: 7'h7F when ACTIVE_LOW=1, 7'h00 when ACTIVE_LOW=0; lit glyphs SHALL be inverted when ACTIVE_LOW=0.
REQ-020 SHALL run a free-running prescaler counting 0..BLINK_DIV-1, wrapping to 0; blink_phase SHALL toggle on the edge where the counter wraps.
REQ-021 Prescaler and blink_phase SHALL be unaffected by load; a load and a wrap on the same edge SHALL both take effect.
REQ-022 Changes to lz_suppress or blink_phase SHALL reach seg_out one edge later (output register only).
REQ-023 Prescaler width SHALL be clog2(BLINK_DIV); no counter overflow beyond BLINK_DIV-1.

Reset
REQ-024 While reset_n=0: shadow registers 0, shown=0, prescaler 0, blink_phase 0, seg_out all dark per ACTIVE_LOW.
REQ-025 Reset asserted mid-operation SHALL take effect immediately (asynchronously) and discard any load in progress; first load after deassertion SHALL behave as the first load after power-up.

Structure
REQ-026 SHALL place the hex glyph table constants and the dark-pattern constant in the shared display package used by existing display blocks.
REQ-027 SHALL reuse the existing hexdigit sub-module (4-bit in, 7-bit active-low segments), instantiated N_DIGITS times via generate; suppression, blink and polarity logic SHALL remain in hex_display_ctrl.

Verification (bench: N_DIGITS=4, BLINK_DIV=4, ACTIVE_LOW=1)
REQ-028 Reset release, no load -> seg_out = 28'hFFFFFFF indefinitely, blink_phase toggling every 4 cycles.
REQ-029 load=1 one cycle, data_in=16'h12AF, masks 0 -> seg_out shows 1,2,A,F exactly 2 edges later, held thereafter.
REQ-030 data_in=16'h0050, lz_suppress=1 -> digits 3,2 dark, digit 1 "5", digit 0 "0"; data_in=16'h0000 -> only digit 0 lit "0"; lz_suppress=0 -> all four "0".
REQ-031 data_in=16'h1234, blink_in=4'b0001 -> digit 0 dark exactly while blink_phase=1, other digits steady; blank_in=4'b0100 -> digit 2 always dark.
REQ-032 Loads on 3 consecutive cycles (16'h1111, 16'h2222, 16'h3333) -> seg_out shows each for one cycle, final 3333, latency 2 each.
REQ-033 reset_n pulsed low mid-run after a load -> seg_out dark immediately, prescaler restarts at 0, digits stay dark until next load.
